// File: rtl/axil_seq_wr_rd_master.sv
// AXI4-Lite self-test master: writes NUM_REGS sequential words, reads them back and counts errors.
// Optional build macro AXIL_SEQ_TIMEOUT_EN adds a per-state wait limit of TIMEOUT_CYCLES.
module axil_seq_wr_rd_master #(
    parameter int          ADDR_WIDTH     = 4,
    parameter int          DATA_WIDTH     = 32,
    parameter int          NUM_REGS       = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] SEED           = 32'h0000_0001,
    parameter int          TIMEOUT_CYCLES = 256,
    localparam int         ERR_W          = $clog2(NUM_REGS + 1) + 1
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ERR_W-1:0]        err_count,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [3:0]              M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam int                IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WRESP, S_RD, S_RDATA, S_FIN
    } state_t;

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [IDX_W-1:0] idx);
        return ADDR_WIDTH'(BASE_ADDR + (32'(idx) << 2));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] data_of(input logic [IDX_W-1:0] idx);
        return DATA_WIDTH'(SEED + 32'(idx));
    endfunction

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [ERR_W-1:0]        r_err;
    logic                    r_busy, r_done, r_pass;
    logic                    r_aw_done, r_w_done;
    logic [ADDR_WIDTH-1:0]   r_awaddr, r_araddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;

    logic                    w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic                    w_wr_done, w_rd_err, w_last;
    logic                    w_state_done;
    logic [IDX_W-1:0]        w_idx_next;
    logic [ERR_W-1:0]        w_err_inc, w_err_after_r;

    assign w_aw_hs    = r_awvalid & M_AXI_AWREADY;
    assign w_w_hs     = r_wvalid  & M_AXI_WREADY;
    assign w_b_hs     = r_bready  & M_AXI_BVALID;
    assign w_ar_hs    = r_arvalid & M_AXI_ARREADY;
    assign w_r_hs     = r_rready  & M_AXI_RVALID;
    // AW and W may complete in either order; the pair is finished once both have handshaken.
    assign w_wr_done  = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
    assign w_last     = (r_idx == LAST_IDX);
    assign w_idx_next = r_idx + IDX_ONE;
    assign w_err_inc  = (r_err == ERR_MAX) ? r_err : r_err + ERR_ONE;
    assign w_rd_err   = (M_AXI_RDATA != data_of(r_idx)) || (M_AXI_RRESP != 2'b00);
    assign w_err_after_r = w_rd_err ? w_err_inc : r_err;

    always_comb begin
        w_state_done = 1'b0;
        case (r_state)
            S_IDLE:  w_state_done = start;
            S_WR:    w_state_done = w_wr_done;
            S_WRESP: w_state_done = w_b_hs;
            S_RD:    w_state_done = w_ar_hs;
            S_RDATA: w_state_done = w_r_hs;
            default: w_state_done = 1'b1;
        endcase
    end

`ifdef AXIL_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_tmo;

    assign w_tmo = (r_state inside {S_WR, S_WRESP, S_RD, S_RDATA}) &&
                   (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Restarts on every state change so each channel wait gets its own budget.
    always_ff @(posedge ACLK) begin
        if (ARESET || r_state == S_IDLE || w_state_done || w_tmo)
            r_tmo_cnt <= '0;
        else
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_err     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awaddr  <= '0;
            r_araddr  <= '0;
            r_wdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy    <= 1'b1;
                        r_err     <= '0;
                        r_idx     <= '0;
                        r_awaddr  <= addr_of('0);
                        r_wdata   <= data_of('0);
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= S_WR;
                    end
                end
                S_WR: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_wr_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (w_b_hs) begin
                        r_bready <= 1'b0;
                        if (M_AXI_BRESP != 2'b00)
                            r_err <= w_err_inc;
                        if (w_last) begin
                            r_idx     <= '0;
                            r_araddr  <= addr_of('0);
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD;
                        end else begin
                            r_idx     <= w_idx_next;
                            r_awaddr  <= addr_of(w_idx_next);
                            r_wdata   <= data_of(w_idx_next);
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= S_WR;
                        end
                    end
                end
                S_RD: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (w_r_hs) begin
                        r_rready <= 1'b0;
                        r_err    <= w_err_after_r;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_pass  <= (w_err_after_r == '0);
                            r_state <= S_FIN;
                        end else begin
                            r_idx     <= w_idx_next;
                            r_araddr  <= addr_of(w_idx_next);
                            r_arvalid <= 1'b1;
                            r_state   <= S_RD;
                        end
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
`ifdef AXIL_SEQ_TIMEOUT_EN
            // A stalled channel aborts the run; these assignments win over the case above.
            if (w_tmo && !w_state_done) begin
                r_awvalid <= 1'b0;
                r_wvalid  <= 1'b0;
                r_bready  <= 1'b0;
                r_arvalid <= 1'b0;
                r_rready  <= 1'b0;
                r_err     <= ERR_MAX;
                r_pass    <= 1'b0;
                r_done    <= 1'b1;
                r_busy    <= 1'b0;
                r_state   <= S_FIN;
            end
`endif
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_count     = r_err;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axil_seq_wr_rd_master.sv
// Directed bench for axil_seq_wr_rd_master against a configurable four-register AXI4-Lite slave.
// Define AXIL_SEQ_TIMEOUT_EN for both files to add the stalled-ARREADY scenario.
module tb_axil_seq_wr_rd_master;

    localparam int ERR_W = 4;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              start;
    logic              busy, done, pass;
    logic [ERR_W-1:0]  err_count;
    logic [3:0]        AWADDR, ARADDR;
    logic [2:0]        AWPROT, ARPROT;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0]       WDATA, RDATA;
    logic [3:0]        WSTRB;
    logic [1:0]        BRESP, RRESP;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave configuration, written only by the test tasks.
    int cfg_aw_lat = 0;
    int cfg_w_lat  = 0;
    bit cfg_bresp_err_first = 1'b0;
    bit cfg_corrupt8 = 1'b0;
    bit cfg_r_stall  = 1'b0;
    bit cfg_ar_block = 1'b0;

    // Slave state, written only by the slave process.
    int          aw_cnt, w_cnt;
    bit          aw_got, w_got;
    logic [3:0]  aw_lat_addr;
    logic [31:0] w_lat_data;
    logic [31:0] mem [4];
    int          n_aw, n_w, n_b, n_ar, n_r;
    logic [3:0]  sl_waddr;
    logic [31:0] sl_wdata;

    axil_seq_wr_rd_master #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(4),
        .BASE_ADDR(32'h0), .SEED(32'h1), .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    // Ready latency counts cycles a VALID has waited; latency 0 keeps READY permanently high.
    assign AWREADY  = (aw_cnt >= cfg_aw_lat);
    assign WREADY   = (w_cnt >= cfg_w_lat);
    assign ARREADY  = !cfg_ar_block;
    assign sl_waddr = (AWVALID && AWREADY) ? AWADDR : aw_lat_addr;
    assign sl_wdata = (WVALID && WREADY) ? WDATA : w_lat_data;

    always @(posedge ACLK) begin
        if (ARESET) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            aw_lat_addr <= '0; w_lat_data <= '0;
            BVALID <= 1'b0; BRESP <= 2'b00; RVALID <= 1'b0; RDATA <= '0; RRESP <= 2'b00;
            n_aw <= 0; n_w <= 0; n_b <= 0; n_ar <= 0; n_r <= 0;
            for (int i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            if (AWVALID && AWREADY) begin
                aw_cnt <= 0; aw_got <= 1'b1; aw_lat_addr <= AWADDR; n_aw <= n_aw + 1;
            end else if (AWVALID) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (WVALID && WREADY) begin
                w_cnt <= 0; w_got <= 1'b1; w_lat_data <= WDATA; n_w <= n_w + 1;
            end else if (WVALID) begin
                w_cnt <= w_cnt + 1;
            end
            if ((aw_got || (AWVALID && AWREADY)) && (w_got || (WVALID && WREADY))) begin
                mem[sl_waddr[3:2]] <= sl_wdata;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                BVALID <= 1'b1;
                BRESP  <= (cfg_bresp_err_first && n_b == 0) ? 2'b10 : 2'b00;
            end
            if (BVALID && BREADY) begin
                BVALID <= 1'b0; n_b <= n_b + 1;
            end
            if (ARVALID && ARREADY) begin
                n_ar <= n_ar + 1;
                if (!cfg_r_stall) begin
                    RVALID <= 1'b1;
                    RRESP  <= 2'b00;
                    RDATA  <= (cfg_corrupt8 && ARADDR == 4'h8) ? 32'h5 : mem[ARADDR[3:2]];
                end
            end
            if (RVALID && RREADY) begin
                RVALID <= 1'b0; n_r <= n_r + 1;
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        start  = 1'b0;
        repeat (2) tick();
        ARESET = 1'b0;
        tick();
    endtask

    // Pulses start and counts cycles inclusive of the start cycle until done is seen.
    task automatic run_seq(output int cycles, output bit seen);
        start = 1'b1;
        tick();
        start  = 1'b0;
        cycles = 1;
        while (!done && cycles < 200) begin
            tick();
            cycles++;
        end
        seen = done;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({busy, done, pass, AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 8'h00) begin
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {busy, done, pass, AWVALID, WVALID, BREADY, ARVALID, RREADY});
            n_fail++;
        end
        n_checks++;
        if (err_count !== 4'h0) begin
            $display("FAIL reset_err: got %0h expected 0", err_count); n_fail++;
        end
        n_checks++;
        if ({AWADDR, ARADDR, WDATA} !== 40'h0) begin
            $display("FAIL reset_addr_data: got %h expected 0", {AWADDR, ARADDR, WDATA}); n_fail++;
        end
        n_checks++;
        if ({AWPROT, ARPROT, WSTRB} !== 10'h00F) begin
            $display("FAIL prot_strb: got %h expected 00f", {AWPROT, ARPROT, WSTRB}); n_fail++;
        end
    endtask

    task automatic test_basic();
        int cycles;
        do_reset();
        start = 1'b1;
        tick();
        start  = 1'b0;
        cycles = 1;
        n_checks++;
        if (busy !== 1'b1) begin
            $display("FAIL basic_busy: got %b expected 1", busy); n_fail++;
        end
        // A start pulse mid-sequence must neither restart nor lengthen the run.
        while (!done && cycles < 200) begin
            start = (cycles == 5);
            tick();
            cycles++;
        end
        start = 1'b0;
        n_checks++;
        if (cycles !== 17 || done !== 1'b1) begin
            $display("FAIL basic_latency: got %0d cycles done=%b expected 17 done=1", cycles, done); n_fail++;
        end
        n_checks++;
        if ({pass, busy, err_count} !== 6'b10_0000) begin
            $display("FAIL basic_result: pass=%b busy=%b err=%0h expected pass=1 busy=0 err=0",
                     pass, busy, err_count);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[i] !== 32'(i + 1)) begin
                $display("FAIL basic_mem%0d: got %h expected %h", i, mem[i], 32'(i + 1)); n_fail++;
            end
        end
        n_checks++;
        if ({n_aw, n_w, n_b, n_ar, n_r} !== {32'd4, 32'd4, 32'd4, 32'd4, 32'd4}) begin
            $display("FAIL basic_counts: aw=%0d w=%0d b=%0d ar=%0d r=%0d expected 4 each",
                     n_aw, n_w, n_b, n_ar, n_r);
            n_fail++;
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || pass !== 1'b1) begin
            $display("FAIL basic_done_pulse: done=%b pass=%b expected done=0 pass=1", done, pass); n_fail++;
        end
    endtask

    task automatic test_aw_early();
        int  cycles;
        bit  seen;
        do_reset();
        cfg_w_lat = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({AWVALID, WVALID, AWADDR, WDATA} !== {1'b1, 1'b1, 4'h0, 32'h1}) begin
            $display("FAIL early_issue: awv=%b wv=%b awaddr=%h wdata=%h expected 1 1 0 1",
                     AWVALID, WVALID, AWADDR, WDATA);
            n_fail++;
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({AWVALID, WVALID, BREADY, WDATA} !== {3'b010, 32'h1}) begin
                $display("FAIL early_hold%0d: awv=%b wv=%b bready=%b wdata=%h expected 0 1 0 1",
                         k, AWVALID, WVALID, BREADY, WDATA);
                n_fail++;
            end
        end
        tick();
        n_checks++;
        if ({AWVALID, WVALID, BREADY} !== 3'b001) begin
            $display("FAIL early_wresp: awv=%b wv=%b bready=%b expected 0 0 1", AWVALID, WVALID, BREADY);
            n_fail++;
        end
        cycles = 0;
        while (!done && cycles < 200) begin
            tick();
            cycles++;
        end
        seen = done;
        n_checks++;
        if ({seen, pass, err_count} !== 6'b11_0000) begin
            $display("FAIL early_result: done=%b pass=%b err=%0h expected done=1 pass=1 err=0",
                     seen, pass, err_count);
            n_fail++;
        end
        n_checks++;
        if ({mem[0], mem[1], mem[2], mem[3]} !== {32'h1, 32'h2, 32'h3, 32'h4}) begin
            $display("FAIL early_mem: got %h %h %h %h expected 1 2 3 4", mem[0], mem[1], mem[2], mem[3]);
            n_fail++;
        end
        cfg_w_lat = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        int  cycles;
        bit  seen;
        n_checks++;
        if (pass !== 1'b1) begin
            $display("FAIL mid_precondition_pass: got %b expected 1", pass); n_fail++;
        end
        cfg_r_stall = 1'b1;
        start = 1'b1;
        tick();
        start  = 1'b0;
        cycles = 0;
        while (!RREADY && cycles < 100) begin
            tick();
            cycles++;
        end
        n_checks++;
        if (RREADY !== 1'b1 || ARVALID !== 1'b0) begin
            $display("FAIL mid_reach_rdata: rready=%b arvalid=%b expected 1 0", RREADY, ARVALID); n_fail++;
        end
        repeat (2) tick();
        ARESET = 1'b1;
        tick();
        n_checks++;
        if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, busy, pass, done} !== 8'h00) begin
            $display("FAIL mid_reset_outputs: got %b expected 00000000",
                     {AWVALID, WVALID, ARVALID, BREADY, RREADY, busy, pass, done});
            n_fail++;
        end
        ARESET = 1'b0;
        cfg_r_stall = 1'b0;
        tick();
        run_seq(cycles, seen);
        n_checks++;
        if ({seen, pass, err_count} !== 6'b11_0000 || cycles !== 17) begin
            $display("FAIL mid_rerun: done=%b pass=%b err=%0h cycles=%0d expected 1 1 0 17",
                     seen, pass, err_count, cycles);
            n_fail++;
        end
    endtask

    task automatic test_rdata_err();
        int  cycles;
        bit  seen;
        do_reset();
        cfg_corrupt8 = 1'b1;
        run_seq(cycles, seen);
        n_checks++;
        if ({seen, pass, err_count} !== 6'b10_0001) begin
            $display("FAIL rdata_err_result: done=%b pass=%b err=%0h expected done=1 pass=0 err=1",
                     seen, pass, err_count);
            n_fail++;
        end
        n_checks++;
        if (n_r !== 4 || mem[2] !== 32'h3) begin
            $display("FAIL rdata_err_reads: reads=%0d mem2=%h expected 4 3", n_r, mem[2]); n_fail++;
        end
        cfg_corrupt8 = 1'b0;
    endtask

    task automatic test_bresp_err();
        int  cycles;
        bit  seen;
        do_reset();
        cfg_bresp_err_first = 1'b1;
        run_seq(cycles, seen);
        n_checks++;
        if ({seen, pass, err_count} !== 6'b10_0001) begin
            $display("FAIL bresp_err_result: done=%b pass=%b err=%0h expected done=1 pass=0 err=1",
                     seen, pass, err_count);
            n_fail++;
        end
        n_checks++;
        if ({n_aw, n_b, n_ar, n_r} !== {32'd4, 32'd4, 32'd4, 32'd4} || cycles !== 17) begin
            $display("FAIL bresp_err_complete: aw=%0d b=%0d ar=%0d r=%0d cycles=%0d expected 4 4 4 4 17",
                     n_aw, n_b, n_ar, n_r, cycles);
            n_fail++;
        end
        cfg_bresp_err_first = 1'b0;
    endtask

`ifdef AXIL_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int wait_cnt;
        int ar_cycles;
        do_reset();
        cfg_ar_block = 1'b1;
        start = 1'b1;
        tick();
        start    = 1'b0;
        wait_cnt = 0;
        while (!ARVALID && wait_cnt < 100) begin
            tick();
            wait_cnt++;
        end
        ar_cycles = 0;
        while (ARVALID && ar_cycles < 100) begin
            ar_cycles++;
            tick();
        end
        n_checks++;
        if (ar_cycles !== 16) begin
            $display("FAIL timeout_rd_cycles: got %0d expected 16", ar_cycles); n_fail++;
        end
        n_checks++;
        if ({done, pass, busy, ARVALID, err_count} !== 8'b1000_1111) begin
            $display("FAIL timeout_result: done=%b pass=%b busy=%b arvalid=%b err=%0h expected 1 0 0 0 f",
                     done, pass, busy, ARVALID, err_count);
            n_fail++;
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            $display("FAIL timeout_done_pulse: got %b expected 0", done); n_fail++;
        end
        cfg_ar_block = 1'b0;
    endtask
`endif

    initial begin
        ARESET = 1'b1;
        start  = 1'b0;
        test_reset();
        test_basic();
        test_aw_early();
        test_reset_mid();
        test_rdata_err();
        test_bresp_err();
`ifdef AXIL_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axil_seq_wr_rd_master.md
Name: axil_seq_wr_rd_master

Overview:
- Hardware AXI4-Lite master that sits directly upstream of the CNT_MOD4 slave register bank (S00_AXI) and drives it.
- On a start pulse it writes NUM_REGS sequential 32-bit words, then reads each word back and compares it against the written value.
- Reports pass/fail and an error count to a status register or an ILA.
- Used for on-board self-test of reconfigurable-partition IPs after a DFX load.

Parameters:
ADDR_WIDTH, 4, AXI address width in bits (4 covers 4 registers).
DATA_WIDTH, 32, AXI data width; fixed at 32.
NUM_REGS, 4, number of consecutive registers exercised (1..2**(ADDR_WIDTH-2)).
BASE_ADDR, 0, byte address of the first register; 4-byte aligned.
SEED, 32'h00000001, data written to register 0; register i receives SEED+i (mod 2^32).
TIMEOUT_CYCLES, 256, per-channel wait limit (used only with the optional feature).

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; starts a sequence when idle
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when the sequence finishes
pass  out  1  sticky result of the last sequence; 1 = no errors
err_count  out  $clog2(NUM_REGS+1)+1  mismatches plus non-OKAY responses, saturating
M_AXI_AWADDR  out  ADDR_WIDTH  write address
M_AXI_AWPROT  out  3  always 3'b000
M_AXI_AWVALID  out  1
M_AXI_AWREADY  in  1
M_AXI_WDATA  out  32
M_AXI_WSTRB  out  4  always 4'hF
M_AXI_WVALID  out  1
M_AXI_WREADY  in  1
M_AXI_BRESP  in  2
M_AXI_BVALID  in  1
M_AXI_BREADY  out  1
M_AXI_ARADDR  out  ADDR_WIDTH
M_AXI_ARPROT  out  3  always 3'b000
M_AXI_ARVALID  out  1
M_AXI_ARREADY  in  1
M_AXI_RDATA  in  32
M_AXI_RRESP  in  2
M_AXI_RVALID  in  1
M_AXI_RREADY  out  1

Behaviour:
- Clocking and reset: single clock ACLK; ARESET is synchronous, active-high.
- Reset values (all outputs from registers): every VALID/READY = 0, busy = 0, done = 0, pass = 0, err_count = 0, addresses/data = 0.
- ARESET mid-transaction drops all VALIDs immediately. The downstream slave is assumed to share the reset.

State machine:
- IDLE:
  - start=1 → clear err_count, set idx=0 → WR.
  - start while busy is ignored.
- WR:
  - Assert AWVALID and WVALID together; AWADDR = BASE_ADDR+4*idx, WDATA = SEED+idx.
  - Each VALID drops independently on its own handshake (VALID & READY).
  - Once both have handshaken (same or different cycles) → WRESP.
  - VALID never drops before its handshake, and AWADDR/WDATA stay stable while VALID is high.
- WRESP:
  - BREADY = 1.
  - On BVALID: if BRESP != 2'b00, increment err_count.
  - If idx = NUM_REGS-1 → RD with idx=0; else idx+1 → WR.
- RD: ARVALID = 1, ARADDR = BASE_ADDR+4*idx; on ARREADY → RDATA.
- RDATA:
  - RREADY = 1.
  - On RVALID: error if RDATA != SEED+idx or RRESP != 2'b00; each such beat increments err_count by at most 1.
  - If last idx → FIN; else idx+1 → RD.
- FIN (one cycle): done = 1, pass = (err_count==0), busy = 0 → IDLE.

Timing and ordering:
- Minimum latency with a zero-wait slave: 2 cycles per write + 2 cycles per read, plus 1 cycle for FIN. NUM_REGS=4 → 17 cycles from start to done.
- Only one outstanding transaction at any time; no read is issued before the final B response is received.
- err_count saturates at all-ones.

Optional Feature:
AXIL_SEQ_TIMEOUT_EN
- Defined:
  - A per-state cycle counter resets on each state entry.
  - If a WR/WRESP/RD/RDATA state lasts TIMEOUT_CYCLES cycles without completing: all VALID/READY drop, err_count is set to all-ones, and the FSM goes to FIN (done pulse, pass=0).
- Not defined: no counter is built; the FSM waits indefinitely.

Test Plan:
- Zero-wait slave model, SEED=1, NUM_REGS=4, start pulse → writes 1,2,3,4 to 0x0,0x4,0x8,0xC; reads return the same values; done after 17 cycles; pass=1; err_count=0.
- Slave asserts AWREADY 3 cycles before WREADY → AWVALID drops after its handshake, WVALID holds with stable WDATA, and WRESP is entered only after both handshakes; pass=1.
- Slave returns RDATA=0x5 for address 0x8 → err_count=1, pass=0; the other three reads compare clean.
- Slave returns BRESP=2'b10 on the first write → err_count=1, pass=0; the sequence still completes all 8 transactions.
- ARESET asserted during RDATA wait → next cycle: all VALIDs=0, busy=0, pass=0. A new start after release gives a full passing run.
- With AXIL_SEQ_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, slave never asserts ARREADY → after 16 cycles in RD: done pulse, pass=0, err_count=all-ones, ARVALID=0.
